bsg_xnor_dot: RTL

BSG_XNOR_DOT -- requirements
Module: bsg_xnor_dot

---
 rtl/bsg_xnor_dot_pkg.sv | 15 +
 rtl/bsg_xnor_popcount.sv | 27 ++
 rtl/bsg_xnor_dot.sv | 115 +++++++++++
 3 files changed

// File: rtl/bsg_xnor_dot_pkg.sv
// Shared types for the XNOR dot-product block.
// FSM state encoding and counter width helper.
package bsg_xnor_dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int cnt_w_f(input int width, input int beats);
    return $clog2(width * beats + 1);
  endfunction

endpackage

// File: rtl/bsg_xnor_popcount.sv
// Per-beat XNOR match count and counted-bit count.
// Purely combinational; mask selects which bits take part.
module bsg_xnor_popcount #(
  parameter int width_p = 16,
  localparam int pw = $clog2(width_p + 1)
) (
  input  logic [width_p-1:0] a,
  input  logic [width_p-1:0] b,
  input  logic [width_p-1:0] mask,
  output logic [pw-1:0]      match,
  output logic [pw-1:0]      bits
);

  logic [width_p-1:0] hit;

  assign hit = ~(a ^ b) & mask;

  always_comb begin
    match = '0;
    bits  = '0;
    for (int i = 0; i < width_p; i++) begin
      match = match + pw'(hit[i]);
      bits  = bits + pw'(mask[i]);
    end
  end

endmodule

// File: rtl/bsg_xnor_dot.sv
// Streaming XNOR dot product with valid/ready in, valid/yumi out.
// Define BSG_XNOR_DOT_MASK_EN to add the per-bit mask_i input.
module bsg_xnor_dot
  import bsg_xnor_dot_pkg::*;
#(
  parameter int width_p = 16,
  parameter int max_beats_p = 64,
  localparam int cnt_w = cnt_w_f(width_p, max_beats_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [cnt_w-1:0]   popcnt_o,
  output logic [cnt_w:0]     dot_o,
  output logic               overflow_o,
  input  logic               yumi_i
`ifdef BSG_XNOR_DOT_MASK_EN
  ,
  input  logic [width_p-1:0] mask_i
`endif
);

  localparam int pw = $clog2(width_p + 1);
  localparam int bw = $clog2(max_beats_p + 1);

  state_e             state;
  logic [cnt_w-1:0]   acc;
  logic [cnt_w-1:0]   bits;
  logic [bw-1:0]      beats;
  logic [width_p-1:0] mask;
  logic [pw-1:0]      match;
  logic [pw-1:0]      mbits;
  logic               accept;
  logic               limit;
  logic               fin;
  logic [cnt_w-1:0]   acc_n;
  logic [cnt_w-1:0]   bits_n;
  logic [bw-1:0]      beats_n;
  logic [cnt_w:0]     dot_n;

`ifdef BSG_XNOR_DOT_MASK_EN
  assign mask = mask_i;
`else
  assign mask = '1;
`endif

  bsg_xnor_popcount #(
    .width_p(width_p)
  ) u_pc (
    .a    (a_i),
    .b    (b_i),
    .mask (mask),
    .match(match),
    .bits (mbits)
  );

  assign ready_o = (state != HOLD);
  assign v_o     = (state == HOLD);
  assign accept  = v_i & ready_o;

  assign acc_n   = acc + cnt_w'(match);
  assign bits_n  = bits + cnt_w'(mbits);
  assign beats_n = beats + bw'(1);
  assign limit   = (beats_n == bw'(max_beats_p));
  assign fin     = last_i | limit;

  // Result lies within +/-bits_n, so modular cnt_w+1 math is exact.
  assign dot_n = {acc_n, 1'b0} - {1'b0, bits_n};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      acc        <= '0;
      bits       <= '0;
      beats      <= '0;
      popcnt_o   <= '0;
      dot_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= acc_n;
            bits  <= bits_n;
            beats <= beats_n;
            if (fin) begin
              state      <= HOLD;
              popcnt_o   <= acc_n;
              dot_o      <= dot_n;
              overflow_o <= ~last_i;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (yumi_i) begin
            state      <= IDLE;
            acc        <= '0;
            bits       <= '0;
            beats      <= '0;
            overflow_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
